multiword_addsub_sequencer: RTL and testbench



---
 rtl/multiword_addsub_sequencer_pkg.sv | 18 +
 rtl/multiword_addsub_sequencer_if.sv | 24 ++
 rtl/adder_and_subtractor.sv | 25 ++
 rtl/multiword_addsub_sequencer.sv | 113 +++++++++++
 tb/tb_multiword_addsub_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/multiword_addsub_sequencer_pkg.sv
// Shared types for the multi-word add/subtract sequencer: FSM state encoding,
// default geometry and the slice-index width helper.
package multiword_addsub_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int WORDS_DEF      = 4;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_addsub_sequencer_if.sv
// Request/result bundle of the sequencer; master issues operands and START,
// slave returns BUSY/DONE and the registered result.
interface multiword_addsub_sequencer_if
    import multiword_addsub_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WORDS      = WORDS_DEF
);
    logic                          start;
    logic                          sub;
    logic                          ci;
    logic [DATA_WIDTH*WORDS-1:0]   a;
    logic [DATA_WIDTH*WORDS-1:0]   b;
    logic                          busy;
    logic                          done;
    logic [DATA_WIDTH*WORDS-1:0]   s;
    logic                          co;
    logic                          ovf;

    modport master (output start, sub, ci, a, b,
                    input  busy, done, s, co, ovf);
    modport slave  (input  start, sub, ci, a, b,
                    output busy, done, s, co, ovf);
endinterface

// File: rtl/adder_and_subtractor.sv
// One DATA_WIDTH slice, purely combinational; in subtract mode ci_i is a
// borrow-in and co_o a borrow-out, so slices chain CO->CI in either mode.
module adder_and_subtractor
    import multiword_addsub_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  sub_i,
    input  logic                  ci_i,
    output logic [DATA_WIDTH-1:0] s_o,
    output logic                  co_o
);
    logic [DATA_WIDTH:0] sum_ext;
    logic [DATA_WIDTH:0] dif_ext;
    logic [DATA_WIDTH:0] ci_ext;

    assign ci_ext  = {{DATA_WIDTH{1'b0}}, ci_i};
    assign sum_ext = {1'b0, a_i} + {1'b0, b_i} + ci_ext;
    // b_i + ci_i never exceeds 2^DATA_WIDTH, so the wrapped top bit is exactly the borrow
    assign dif_ext = {1'b0, a_i} - {1'b0, b_i} - ci_ext;

    assign {co_o, s_o} = sub_i ? dif_ext : sum_ext;
endmodule

// File: rtl/multiword_addsub_sequencer.sv
// Multi-precision add/sub over WORDS slices, LSB first; DONE WORDS+1 cycles after
// START, START ignored while BUSY (no queueing), back-to-back accepted in DONE.
module multiword_addsub_sequencer
    import multiword_addsub_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WORDS      = WORDS_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    multiword_addsub_sequencer_if.slave bus
);
    localparam int                N     = DATA_WIDTH * WORDS;
    localparam int                IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d, s_q, s_d;
    logic              sub_q, sub_d, ci_q, ci_d, carry_q, carry_d;
    logic              co_q, co_d, ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] slice_a, slice_b, slice_s;
    logic                  slice_ci, slice_co, accept;
    int                    base;

    always_comb base = int'(idx_q) * DATA_WIDTH;

    assign slice_a  = a_q[base +: DATA_WIDTH];
    assign slice_b  = b_q[base +: DATA_WIDTH];
    assign slice_ci = (idx_q == '0) ? ci_q : carry_q;
    assign accept   = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    adder_and_subtractor #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .sub_i (sub_q),
        .ci_i  (slice_ci),
        .s_o   (slice_s),
        .co_o  (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        ci_d    = ci_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            sub_d   = bus.sub;
            ci_d    = bus.ci;
            idx_d   = '0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    s_d[base +: DATA_WIDTH] = slice_s;
                    carry_d = slice_co;
                    if (idx_q == LAST) begin
                        co_d    = slice_co;
                        // Signed overflow: operands agree in sign (add) or differ (sub) and result sign flips
                        ovf_d   = ((a_q[N-1] ^ b_q[N-1]) == sub_q) &&
                                  (slice_s[DATA_WIDTH-1] != a_q[N-1]);
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            ci_q    <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            ci_q    <= ci_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Bench for the 4x8-bit sequencer: directed corner cases, timing and reset
// scenarios, then randomized back-to-back ops against a full-width arithmetic model.
module tb_multiword_addsub_sequencer;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int N  = DW * W;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    multiword_addsub_sequencer_if #(.DATA_WIDTH(DW), .WORDS(W)) bus ();

    multiword_addsub_sequencer #(.DATA_WIDTH(DW), .WORDS(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, input logic ci);
        bus.a = a; bus.b = b; bus.sub = sub; bus.ci = ci;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // lat counts cycles after the START edge; returns with DONE high or at the bound
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cycles++;
            cyc();
            lat++;
        end
    endtask

    // Full-width arithmetic reference
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic sub, input logic ci,
                                  output logic [N-1:0] s, output logic co,
                                  output logic ovf);
        logic [N:0] full;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
            s    = full[N-1:0];
            co   = full[N];
            ovf  = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
        end else begin
            full = {1'b0, a} - {1'b0, b} - (N+1)'(ci);
            s    = full[N-1:0];
            co   = ({1'b0, a} < ({1'b0, b} + (N+1)'(ci)));
            ovf  = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.ci = 1'b0; bus.a = '0; bus.b = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        chk_cnt++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_flags got=%b want=00", {bus.busy, bus.done}); else pass_cnt++;
        chk_cnt++; if ({bus.s, bus.co, bus.ovf} !== '0) $display("FAIL reset_result s=%h co=%b ovf=%b want 0", bus.s, bus.co, bus.ovf); else pass_cnt++;
    endtask

    task automatic test_timing();
        int lat, bc;
        launch(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        wait_done(lat, bc);
        chk_cnt++; if (lat !== 5) $display("FAIL timing_latency got=%0d want=5", lat); else pass_cnt++;
        chk_cnt++; if (bc !== 4) $display("FAIL timing_busy_cycles got=%0d want=4", bc); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL timing_busy_in_done got=%b want=0", bus.busy); else pass_cnt++;
        chk_cnt++; if ({bus.s, bus.co, bus.ovf} !== {32'h00000100, 1'b0, 1'b0})
            $display("FAIL timing_result s=%h co=%b ovf=%b want s=00000100 co=0 ovf=0", bus.s, bus.co, bus.ovf); else pass_cnt++;
        cyc();
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL timing_done_pulse got=%b want=0", bus.done); else pass_cnt++;
        cyc();
        chk_cnt++; if ({bus.s, bus.co} !== {32'h00000100, 1'b0}) $display("FAIL timing_hold s=%h co=%b want s=00000100 co=0", bus.s, bus.co); else pass_cnt++;
    endtask

    task automatic test_corners();
        logic [N-1:0] ta [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 32'h000000FF};
        logic [N-1:0] tb [5] = '{32'h00000000, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
        logic         tsub[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic         tci [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [N-1:0] es  [5] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000100};
        logic         eco [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         eov [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int lat, bc;
        for (int i = 0; i < 5; i++) begin
            launch(ta[i], tb[i], tsub[i], tci[i]);
            wait_done(lat, bc);
            chk_cnt++;
            if ({bus.done, bus.s, bus.co, bus.ovf} !== {1'b1, es[i], eco[i], eov[i]})
                $display("FAIL corner_%0d done=%b s=%h co=%b ovf=%b want done=1 s=%h co=%b ovf=%b",
                         i, bus.done, bus.s, bus.co, bus.ovf, es[i], eco[i], eov[i]);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [N-1:0] es; logic eco, eov;
        launch(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b1);
        model(32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b1, es, eco, eov);
        cyc();
        bus.start = 1'b1; bus.a = 32'hDEADBEEF; bus.b = 32'hCAFEF00D; bus.sub = 1'b0; bus.ci = 1'b0;
        cyc();
        bus.start = 1'b0;
        wait_done(lat, bc);
        chk_cnt++; if (lat !== 3) $display("FAIL ignore_start_latency got=%0d want=3", lat); else pass_cnt++;
        chk_cnt++; if ({bus.s, bus.co, bus.ovf} !== {es, eco, eov})
            $display("FAIL ignore_midrun s=%h co=%b ovf=%b want s=%h co=%b ovf=%b", bus.s, bus.co, bus.ovf, es, eco, eov); else pass_cnt++;
        launch(32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1);
        model(32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1, es, eco, eov);
        wait_done(lat, bc);
        chk_cnt++; if (lat !== 5) $display("FAIL b2b_latency got=%0d want=5", lat); else pass_cnt++;
        chk_cnt++; if ({bus.s, bus.co, bus.ovf} !== {es, eco, eov})
            $display("FAIL b2b_result s=%h co=%b ovf=%b want s=%h co=%b ovf=%b", bus.s, bus.co, bus.ovf, es, eco, eov); else pass_cnt++;
        cyc();
        chk_cnt++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL b2b_to_idle got=%b want=00", {bus.busy, bus.done}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dones;
        logic [N-1:0] es; logic eco, eov;
        launch(32'h80000000, 32'h80000000, 1'b0, 1'b0);
        wait_done(lat, bc);
        cyc();
        launch(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk_cnt++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL midreset_flags got=%b want=00", {bus.busy, bus.done}); else pass_cnt++;
        chk_cnt++; if ({bus.s, bus.co, bus.ovf} !== '0)
            $display("FAIL midreset_result s=%h co=%b ovf=%b want 0", bus.s, bus.co, bus.ovf); else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done || bus.busy) dones++;
            cyc();
        end
        chk_cnt++; if (dones !== 0) $display("FAIL midreset_no_done got=%0d active cycles want=0", dones); else pass_cnt++;
        launch(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b1);
        model(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b1, es, eco, eov);
        wait_done(lat, bc);
        chk_cnt++; if ({lat, bus.s, bus.co, bus.ovf} !== {32'd5, es, eco, eov})
            $display("FAIL midreset_recover lat=%0d s=%h co=%b ovf=%b want lat=5 s=%h co=%b ovf=%b",
                     lat, bus.s, bus.co, bus.ovf, es, eco, eov); else pass_cnt++;
        cyc();
    endtask

    task automatic test_random();
        int lat, bc;
        logic [N-1:0] a, b, es;
        logic sub, ci, eco, eov;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom(); b = $urandom();
            if ($urandom_range(0, 7) == 0) a = {~a[N-1], a[N-2:0] | 31'h7FFF0000};
            if ($urandom_range(0, 7) == 0) b = a;
            sub = $urandom_range(0, 1); ci = $urandom_range(0, 1);
            model(a, b, sub, ci, es, eco, eov);
            launch(a, b, sub, ci);
            wait_done(lat, bc);
            chk_cnt++;
            if ({lat, bus.s, bus.co, bus.ovf} !== {32'd5, es, eco, eov})
                $display("FAIL random_%0d a=%h b=%h sub=%b ci=%b lat=%0d s=%h co=%b ovf=%b want lat=5 s=%h co=%b ovf=%b",
                         i, a, b, sub, ci, lat, bus.s, bus.co, bus.ovf, es, eco, eov);
            else pass_cnt++;
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_corners();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
